// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C-controlled PWM LED block.
//   PWM_W    : width of each PWM channel counter and duty value
//   NREG     : number of duty registers / PWM channels
//   REG_INIT : register contents after reset, indexed by register number
//   state_t  : I2C target FSM states
package i2c_slave_pkg;

    localparam int unsigned PWM_W = 8;
    localparam int unsigned NREG  = 8;

    localparam logic [7:0] REG_INIT [NREG] = '{
        8'd1, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd200, 8'd255
    };

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

endpackage

// File: rtl/i2c_slave_pwm_channel.sv
// One PWM channel.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   tick  : one-cycle enable advancing the channel counter
//   duty  : requested duty (0 = always low, 255 = high 255 of 256 ticks)
//   pulse : PWM output, high while counter < shadowed duty
module pwm_channel
    import i2c_slave_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [PWM_W-1:0] duty,
    output logic             pulse
);

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_sh;
    logic             load_pend;

    // The shadow is refreshed once right after reset, then only as the counter
    // wraps, so a register write never changes the width of a running period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            duty_sh   <= '0;
            load_pend <= 1'b1;
        end else begin
            load_pend <= 1'b0;
            if (tick)
                cnt <= cnt + 1'b1;
            if (load_pend || (tick && cnt == '1))
                duty_sh <= duty;
        end
    end

    assign pulse = (cnt < duty_sh);

endmodule

// File: rtl/i2c_slave.sv
// I2C target with eight 8-bit duty registers, each driving one PWM output.
//   clk     : system clock (SCL is oversampled, never used as a clock)
//   rst     : synchronous active-high reset
//   scl     : I2C clock from the bus
//   sda     : I2C data, open-drain (driven 0 or released to z)
//   pwm_out : PWM outputs, bit n follows register n
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR = 7'h42,
    parameter int unsigned PWM_DIV  = 512
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            scl,
    inout  wire             sda,
    output logic [NREG-1:0] pwm_out
);

    localparam int unsigned PS_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    // Input synchronizers and one-cycle history
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl_q, sda_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_q = scl_sync[1];
    assign sda_q = sda_sync[1];

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_q & ~scl_d;
    assign scl_fall  = ~scl_q &  scl_d;
    assign start_det =  scl_q &  scl_d &  sda_d & ~sda_q;
    assign stop_det  =  scl_q &  scl_d & ~sda_d &  sda_q;

    // FSM and register file
    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [2:0] ptr, ptr_n;
    logic       sda_oe, sda_oe_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= REG_INIT[i];
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            ptr     <= ptr_n;
            sda_oe  <= sda_oe_n;
            if (wr_en)
                regs[ptr] <= wr_data;
        end
    end

    // bit_cnt counts scl rises within a byte; in RDATA_ACK the value 9 marks
    // that the master acknowledged and another byte should be loaded.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        sda_oe_n  = sda_oe;
        wr_en     = 1'b0;
        wr_data   = {shift[6:0], sda_q};

        if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_n   = {shift[6:0], sda_q};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (state == WDATA && bit_cnt == 4'd7) begin
                            wr_en = 1'b1;
                            ptr_n = ptr + 3'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (shift[7:1] == I2C_ADDR) begin
                                state_n  = ADDR_ACK;
                                sda_oe_n = 1'b1;
                            end else begin
                                state_n = IDLE;
                            end
                        end else if (state == PTR) begin
                            state_n  = PTR_ACK;
                            sda_oe_n = 1'b1;
                            ptr_n    = shift[2:0];
                        end else begin
                            state_n  = WDATA_ACK;
                            sda_oe_n = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (shift[0]) begin
                            state_n  = RDATA;
                            shift_n  = regs[ptr];
                            sda_oe_n = ~regs[ptr][7];
                        end else begin
                            state_n  = PTR;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_n   = WDATA;
                        bit_cnt_n = '0;
                        sda_oe_n  = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n  = RDATA_ACK;
                            sda_oe_n = 1'b0;
                            ptr_n    = ptr + 3'd1;
                        end else if (bit_cnt != 4'd0) begin
                            shift_n  = {shift[6:0], 1'b0};
                            sda_oe_n = ~shift[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_q)
                            state_n = IDLE;
                        else
                            bit_cnt_n = 4'd9;
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        state_n   = RDATA;
                        bit_cnt_n = '0;
                        shift_n   = regs[ptr];
                        sda_oe_n  = ~regs[ptr][7];
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // PWM prescaler and channels
    logic [PS_W-1:0] ps_cnt;
    logic            tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else if (ps_cnt == PS_W'(PWM_DIV - 1)) begin
            ps_cnt <= '0;
            tick   <= 1'b1;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
            tick   <= 1'b0;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_ch
        pwm_channel u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .duty  (regs[g]),
            .pulse (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda;
    wire        sda;
    logic [7:0] pwm_out;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;

    always #5 clk = ~clk;

    i2c_slave #(.I2C_ADDR(7'h42), .PWM_DIV(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sda),
        .pwm_out (pwm_out)
    );

    int vectors = 0;
    int fails   = 0;
    int drive_cnt = 0;
    int hi [8];
    logic [7:0] model [8];

    // Cycles in which someone other than the master pulls sda low
    always @(posedge clk)
        if (m_sda && sda === 1'b0)
            drive_cnt <= drive_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        wait_n(Q); m_sda = 1'b1;
        wait_n(Q); scl = 1'b1;
        wait_n(Q); m_sda = 1'b0;
        wait_n(Q); scl = 1'b0;
        wait_n(2);
    endtask

    task automatic i2c_stop();
        wait_n(Q); m_sda = 1'b0;
        wait_n(Q); scl = 1'b1;
        wait_n(Q); m_sda = 1'b1;
        wait_n(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            wait_n(Q); m_sda = b[i];
            wait_n(Q); scl = 1'b1;
            wait_n(Q); scl = 1'b0;
            wait_n(2);
        end
        wait_n(Q); m_sda = 1'b1;
        wait_n(Q); scl = 1'b1;
        wait_n(Q / 2); ack = (sda === 1'b0);
        wait_n(Q / 2); scl = 1'b0;
        wait_n(2);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        m_sda = 1'b1;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            wait_n(2 * Q); scl = 1'b1;
            wait_n(Q / 2); d = {d[6:0], (sda === 1'b0) ? 1'b0 : 1'b1};
            wait_n(Q / 2); scl = 1'b0;
            wait_n(2);
        end
        wait_n(Q); m_sda = mack ? 1'b0 : 1'b1;
        wait_n(Q); scl = 1'b1;
        wait_n(Q); scl = 1'b0;
        wait_n(2); m_sda = 1'b1;
    endtask

    task automatic count_pwm(input int n);
        for (int c = 0; c < 8; c++) hi[c] = 0;
        for (int k = 0; k < n; k++) begin
            wait_n(1);
            for (int c = 0; c < 8; c++) hi[c] += int'(pwm_out[c]);
        end
    endtask

    // Set pointer p, then read n bytes and compare with the bench model
    task automatic read_regs(input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        write_byte(8'h84, ack); check("rr_addr_w_ack", 32'(ack), 1);
        write_byte(p, ack);     check("rr_ptr_ack", 32'(ack), 1);
        i2c_start();
        write_byte(8'h85, ack); check("rr_addr_r_ack", 32'(ack), 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, d);
            check($sformatf("rd_reg%0d", (int'(p) + i) % 8), 32'(d), 32'(model[(int'(p) + i) % 8]));
        end
        i2c_stop();
    endtask

    task automatic load_defaults();
        model[0] = 8'd1;  model[1] = 8'd20;  model[2] = 8'd40;  model[3] = 8'd60;
        model[4] = 8'd80; model[5] = 8'd100; model[6] = 8'd200; model[7] = 8'd255;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         snap;

        rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
        load_defaults();
        wait_n(3);
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_sda", 32'(sda), 1);
        rst = 1'b0;

        // 1: idle PWM over two full periods (512 clk each with PWM_DIV=2)
        wait_n(10);
        count_pwm(1024);
        for (int c = 0; c < 8; c++)
            check($sformatf("pwm_idle_ch%0d", c), 32'(hi[c]), 32'(4 * int'(model[c])));

        // 2: write reg3/reg4
        i2c_start();
        write_byte(8'h84, ack); check("w_addr_ack", 32'(ack), 1);
        write_byte(8'h03, ack); check("w_ptr_ack", 32'(ack), 1);
        write_byte(8'hAA, ack); check("w_d0_ack", 32'(ack), 1);
        write_byte(8'h55, ack); check("w_d1_ack", 32'(ack), 1);
        i2c_stop();
        model[3] = 8'hAA; model[4] = 8'h55;
        wait_n(600);
        count_pwm(512);
        check("pwm_ch3_new", 32'(hi[3]), 340);
        check("pwm_ch4_new", 32'(hi[4]), 170);
        check("pwm_ch5_same", 32'(hi[5]), 200);

        // 3: pointer 2, repeated start, read 40, 0xAA, 0x55
        i2c_start();
        write_byte(8'h84, ack); check("r_addr_w_ack", 32'(ack), 1);
        write_byte(8'h02, ack); check("r_ptr_ack", 32'(ack), 1);
        i2c_start();
        write_byte(8'h85, ack); check("r_addr_r_ack", 32'(ack), 1);
        read_byte(1'b1, d); check("r_byte0", 32'(d), 40);
        read_byte(1'b1, d); check("r_byte1", 32'(d), 32'hAA);
        read_byte(1'b0, d); check("r_byte2", 32'(d), 32'h55);
        i2c_stop();

        // 4: foreign address 0x50 -> no ACK, sda untouched
        snap = drive_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("foreign_nack", 32'(ack), 0);
        write_byte(8'h01, ack); check("foreign_data_nack", 32'(ack), 0);
        i2c_stop();
        check("foreign_no_drive", 32'(drive_cnt - snap), 0);
        read_regs(8'h00, 8);

        // 5: pointer 7, two bytes -> reg7 then wrap to reg0
        i2c_start();
        write_byte(8'h84, ack); check("wrap_addr_ack", 32'(ack), 1);
        write_byte(8'h07, ack); check("wrap_ptr_ack", 32'(ack), 1);
        write_byte(8'h10, ack); check("wrap_d0_ack", 32'(ack), 1);
        write_byte(8'h20, ack); check("wrap_d1_ack", 32'(ack), 1);
        i2c_stop();
        model[7] = 8'h10; model[0] = 8'h20;
        read_regs(8'h07, 8);

        // 6: reset while the target drives bit 7 (=0) of reg0 = 0x20
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h85, ack); check("mid_addr_r_ack", 32'(ack), 1);
        wait_n(Q);
        check("mid_sda_driven", 32'(sda), 0);
        rst = 1'b1;
        wait_n(1);
        check("mid_rst_sda_release", 32'(sda), 1);
        check("mid_rst_pwm", 32'(pwm_out), 0);
        rst = 1'b0;
        i2c_stop();
        load_defaults();
        read_regs(8'h00, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
